kaf_readout_seq: RTL

- Sequences one full-frame readout of the KAF CCD and the AD9826 digitiser.
- Drives the kaf_v1/v2/h1/r and kaf_amp clocks and the AD9826 CDS/ADC clocks.
- Captures the two-byte-per-pixel AD9826 output and streams it, high byte first, to the FT245 TX FIFO.
- Sits between the command decoder (which pulses start on cmd_read_ccd) and the TX path. It paces rows on downstream FIFO room, so the CCD never stalls mid-row.

---
 rtl/kaf_readout_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/kaf_readout_seq.sv
// KAF CCD + AD9826 full-frame readout sequencer.
// Generates the CCD and digitiser clocks for each row and streams the captured
// pixel bytes (high byte first) to the TX FIFO. Rows start only when the FIFO
// has room for a whole row, so a row is never interrupted once started.
module kaf_readout_seq #(
    parameter int unsigned N_ROWS   = 512,
    parameter int unsigned N_COLS   = 768,
    parameter int unsigned AD_PIPE  = 3,
    parameter int unsigned V_CYC    = 16,
    parameter int unsigned H_SETTLE = 32,
    parameter int unsigned AMP_CYC  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       row_room,
    input  logic       fifo_full,
    input  logic [7:0] ad_data,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [7:0] pix_data,
    output logic       pix_wr,
    output logic       kaf_v1,
    output logic       kaf_v2,
    output logic       kaf_h1,
    output logic       kaf_r,
    output logic       kaf_amp,
    output logic       ad_cdsclk1,
    output logic       ad_cdsclk2,
    output logic       ad_adclk
);

    localparam int unsigned NSlots = N_COLS + AD_PIPE;
    localparam int unsigned CntMax = (AMP_CYC > V_CYC) ?
                                     ((AMP_CYC > H_SETTLE) ? AMP_CYC : H_SETTLE) :
                                     ((V_CYC > H_SETTLE) ? V_CYC : H_SETTLE);
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned RowW   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned SlotW  = (NSlots > 1) ? $clog2(NSlots) : 1;

    typedef enum logic [2:0] {
        StIdle, StAmpOn, StWaitRoom, StVxferA, StVxferB, StHsettle, StPixel, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [2:0]       phase_q, phase_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       pix_data_q, pix_data_d;
    logic             pix_wr_q, pix_wr_d;
    logic             busy_q, busy_d, done_q, done_d, amp_q, amp_d;
    logic             v1_q, v1_d, v2_q, v2_d, h1_q, h1_d, r_q, r_d;
    logic             cds1_q, cds1_d, cds2_q, cds2_d, adclk_q, adclk_d;
    logic             pix_d;

    // Next-state sequencing; outputs are decoded from the next state so that
    // every output is a flop that matches the state it is in.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        slot_d     = slot_q;
        phase_d    = phase_q;
        overrun_d  = overrun_q;
        pix_data_d = pix_data_q;
        pix_wr_d   = 1'b0;

        // The byte on the bus this cycle is written regardless of FIFO state.
        if (pix_wr_q && fifo_full) overrun_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d   = StAmpOn;
                    cnt_d     = '0;
                    row_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            StAmpOn: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(AMP_CYC - 1)) begin
                    state_d = StWaitRoom;
                    cnt_d   = '0;
                end
            end
            StWaitRoom: begin
                if (row_room) begin
                    state_d = StVxferA;
                    cnt_d   = '0;
                end
            end
            StVxferA: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(V_CYC - 1)) begin
                    state_d = StVxferB;
                    cnt_d   = '0;
                end
            end
            StVxferB: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(V_CYC - 1)) begin
                    state_d = StHsettle;
                    cnt_d   = '0;
                end
            end
            StHsettle: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(H_SETTLE - 1)) begin
                    state_d = StPixel;
                    cnt_d   = '0;
                    slot_d  = '0;
                    phase_d = '0;
                end
            end
            StPixel: begin
                phase_d = phase_q + 3'd1;
                // Early slots only flush the AD9826 pipeline.
                if ((phase_q == 3'd3 || phase_q == 3'd7) && slot_q >= SlotW'(AD_PIPE)) begin
                    pix_wr_d   = 1'b1;
                    pix_data_d = ad_data;
                end
                if (phase_q == 3'd7) begin
                    slot_d = slot_q + SlotW'(1);
                    if (slot_q == SlotW'(NSlots - 1)) begin
                        if (row_q == RowW'(N_ROWS - 1)) begin
                            state_d = StDone;
                        end else begin
                            row_d   = row_q + RowW'(1);
                            state_d = StWaitRoom;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q != StIdle && abort) begin
            state_d  = StIdle;
            pix_wr_d = 1'b0;
        end

        if (state_d == StIdle) pix_data_d = 8'h00;

        pix_d   = (state_d == StPixel);
        busy_d  = (state_d != StIdle);
        amp_d   = (state_d != StIdle);
        done_d  = (state_d == StDone);
        v1_d    = (state_d != StVxferA);
        v2_d    = (state_d == StVxferA);
        r_d     = pix_d && (phase_d == 3'd0);
        h1_d    = pix_d && (phase_d < 3'd4);
        adclk_d = pix_d && (phase_d < 3'd4);
        cds1_d  = pix_d && (phase_d == 3'd2);
        cds2_d  = pix_d && (phase_d == 3'd6);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            row_q      <= '0;
            slot_q     <= '0;
            phase_q    <= '0;
            overrun_q  <= 1'b0;
            pix_data_q <= 8'h00;
            pix_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            amp_q      <= 1'b0;
            v1_q       <= 1'b1;
            v2_q       <= 1'b0;
            h1_q       <= 1'b0;
            r_q        <= 1'b0;
            cds1_q     <= 1'b0;
            cds2_q     <= 1'b0;
            adclk_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            slot_q     <= slot_d;
            phase_q    <= phase_d;
            overrun_q  <= overrun_d;
            pix_data_q <= pix_data_d;
            pix_wr_q   <= pix_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            amp_q      <= amp_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            h1_q       <= h1_d;
            r_q        <= r_d;
            cds1_q     <= cds1_d;
            cds2_q     <= cds2_d;
            adclk_q    <= adclk_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign pix_data   = pix_data_q;
    assign pix_wr     = pix_wr_q;
    assign kaf_v1     = v1_q;
    assign kaf_v2     = v2_q;
    assign kaf_h1     = h1_q;
    assign kaf_r      = r_q;
    assign kaf_amp    = amp_q;
    assign ad_cdsclk1 = cds1_q;
    assign ad_cdsclk2 = cds2_q;
    assign ad_adclk   = adclk_q;

endmodule
